mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Initiator side of the single-port on-chip memory interface (valid/instr/addr/wdata/wstrb -> rdata/ready).
- Accepts load/store requests from a CPU pipeline stage: byte, halfword or word, signed or unsigned.
- Drives the memory port, formats write strobes and write data, and extracts and sign-extends load data.
- One request outstanding at a time; sits between the load/store unit (or fetch unit) and the memory.

Parameters:
- TIMEOUT_CYCLES, 256: cycles in BUSY without mem_ready before an error response. Used only when MEM_INIT_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_write  in  1  1 = store, 0 = load
- req_instr  in  1  instruction-fetch tag, forwarded to mem_instr
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result, right-aligned and extended; 0 for stores and errors
- rsp_error  out  1  misaligned, reserved size, or timeout
- mem_valid  out  1  memory request strobe
- mem_instr  out  1  fetch tag
- mem_addr  out  32  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes; 0000 for loads
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory response

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. State returns to IDLE.
- req_ready is 1 in IDLE from the first cycle after reset deasserts; it is 0 in every other state.

State machine:
- IDLE
  - Accept when req_valid && req_ready.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size=3) -> ERR. No memory access is made.
  - Otherwise, on the next cycle drive mem_valid=1 for exactly one cycle, with mem_addr={addr[31:2],2'b00}, mem_wstrb and mem_wdata as below, then -> BUSY.
- BUSY
  - mem_valid=0. Wait for mem_ready.
  - On mem_ready: capture the extracted data, and on the next cycle pulse rsp_valid=1, rsp_error=0. -> IDLE.
- ERR
  - Next cycle: rsp_valid=1, rsp_error=1, rsp_rdata=0. -> IDLE.

Latency:
- Accept at edge N, mem_valid high in cycle N+1.
- With a responder that answers one cycle later, mem_ready is high in N+2 and rsp_valid is high in N+3.
- Misaligned request: rsp_valid in N+1.

Store formatting (o = addr[1:0]):
- Byte: wstrb = 0001<<o; wdata = {4{wdata[7:0]}}.
- Half: wstrb = 0011<<o; wdata = {2{wdata[15:0]}}.
- Word: wstrb = 1111; wdata unchanged.

Load extraction:
- Shift mem_rdata right by 8*o, keep 8, 16 or 32 bits.
- req_signed=1: sign-extend. req_signed=0: zero-extend.
- Store response: rsp_rdata=0.

Boundary conditions:
- mem_ready seen in IDLE or ERR is ignored.
- mem_ready coincident with mem_valid is ignored, because BUSY is not yet entered.
- req_valid while not in IDLE: not accepted; the requester must hold it.
- After a response, req_ready returns to 1 in the same cycle rsp_valid pulses. Back-to-back requests therefore issue every 3 cycles with a 1-cycle responder.
- rst high mid-request: the in-flight response is dropped and no rsp_valid is generated. A later stale mem_ready is ignored, since it arrives in IDLE.
- Request fields are latched at accept; upstream may change them afterwards.

Optional Feature:
- Macro MEM_INIT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ready: rsp_valid=1, rsp_error=1, rsp_rdata=0 next cycle, -> IDLE.
  - mem_ready in the same cycle as the terminal count wins, giving a normal response.
  - A late mem_ready is ignored in IDLE.
- Undefined: no counter, and BUSY waits indefinitely.

Test Plan:
- Word store addr 0x100, data 0xDEADBEEF -> mem_valid one cycle, mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF; rsp_valid 2 cycles after mem_valid (1-cycle responder), rsp_rdata 0, rsp_error 0.
- Byte store addr 0x103, data 0x000000A5 -> mem_addr 0x100, wstrb 1000, wdata 0xA5A5A5A5.
- Signed half load addr 0x102, memory word 0x8001_1234 -> rsp_rdata 0xFFFF8001. Unsigned -> 0x00008001. Signed byte at 0x101 of 0x0000F200 -> 0xFFFFFFF2.
- Word load addr 0x106 -> no mem_valid; rsp_valid next cycle with rsp_error=1, rsp_rdata 0.
- Responder never answers, with MEM_INIT_TIMEOUT_EN and TIMEOUT_CYCLES=8 -> rsp_error pulse after 8 BUSY cycles; an injected mem_ready 3 cycles later produces no rsp_valid.
- rst asserted in BUSY, then mem_ready arrives -> no rsp_valid; req_ready=1 the cycle after rst drops; the next load completes normally.

Source files
------------

// File: rtl/mem_initiator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_initiator                                            |
// | Description : Single-outstanding load/store initiator for the on-chip  |
// |               memory port. Formats store strobes/data, extracts and    |
// |               sign/zero-extends load data, and flags misaligned        |
// |               requests.                                                |
// |               Optional BUSY watchdog enabled by `MEM_INIT_TIMEOUT_EN`. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mem_initiator #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_instr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    // ISSUE is the single cycle mem_valid is high; mem_ready is only
    // honoured once BUSY is entered on the following cycle.
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_BUSY  = 2'd2;
    localparam logic [1:0] c_ERR   = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    // A zero-cycle watchdog would fire before the memory could ever answer.
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_off;

    logic        w_misaligned;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

`ifdef MEM_INIT_TIMEOUT_EN
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_tmo_cnt;
`endif

    // Request decode: alignment check plus store lane replication/strobes.
    always_comb begin
        w_misaligned = 1'b0;
        w_wstrb      = 4'b0000;
        w_wdata      = req_wdata;
        case (req_size)
            c_SZ_BYTE: begin
                w_wstrb = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_misaligned = req_addr[0];
                w_wstrb      = 4'b0011 << req_addr[1:0];
                w_wdata      = {2{req_wdata[15:0]}};
            end
            c_SZ_WORD: begin
                w_misaligned = (req_addr[1:0] != 2'b00);
                w_wstrb      = 4'b1111;
            end
            default: begin
                w_misaligned = 1'b1;
            end
        endcase
        if (!req_write) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load extraction from the latched lane offset, size and signedness.
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        w_load    = w_shifted;
        case (r_size)
            c_SZ_BYTE: w_load = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            c_SZ_HALF: w_load = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default:   w_load = w_shifted;
        endcase
    end

    // Control FSM; every port output is driven from this register block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_write   <= 1'b0;
            r_size    <= 2'b00;
            r_signed  <= 1'b0;
            r_off     <= 2'b00;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_error <= 1'b0;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
`ifdef MEM_INIT_TIMEOUT_EN
            r_tmo_cnt <= 32'h0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        r_write   <= req_write;
                        r_size    <= req_size;
                        r_signed  <= req_signed;
                        r_off     <= req_addr[1:0];
                        if (w_misaligned) begin
                            // Error responds immediately; the memory is never touched.
                            r_state   <= c_ERR;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            r_state   <= c_ISSUE;
                            mem_valid <= 1'b1;
                            mem_instr <= req_instr;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wstrb <= w_wstrb;
                            mem_wdata <= w_wdata;
                        end
                    end
                end
                c_ISSUE: begin
                    mem_valid <= 1'b0;
                    r_state   <= c_BUSY;
`ifdef MEM_INIT_TIMEOUT_EN
                    r_tmo_cnt <= 32'h0;
`endif
                end
                c_BUSY: begin
                    if (mem_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= r_write ? 32'h0 : w_load;
                        req_ready <= 1'b1;
                        r_state   <= c_IDLE;
                    end
`ifdef MEM_INIT_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= 32'h0;
                        req_ready <= 1'b1;
                        r_state   <= c_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
`else
                    // Without the watchdog BUSY waits for mem_ready indefinitely.
`endif
                end
                c_ERR: begin
                    req_ready <= 1'b1;
                    r_state   <= c_IDLE;
                end
                default: begin
                    req_ready <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mem_initiator                                         |
// | Description : Directed self-checking bench for mem_initiator with a    |
// |               hand-driven one-cycle memory responder.                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mem_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_instr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_checks = 0;
    int n_fails  = 0;

    mem_initiator #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_instr  (req_instr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Bounded wait (at negedges) for req_ready, then checked.
    task automatic wait_ready(input string tag);
        for (int k = 0; k < 16 && req_ready !== 1'b1; k++) @(negedge clk);
        check_val({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // One aligned request with a one-cycle responder. Called and returns at a negedge.
    task automatic do_req(input string tag, input logic wr, input logic instr,
                          input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mword, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input logic early);
        wait_ready(tag);
        req_valid = 1'b1; req_write = wr; req_instr = instr; req_size = size;
        req_signed = sgn; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~wr; req_instr = ~instr; req_size = ~size;
        req_signed = ~sgn; req_addr = ~addr; req_wdata = ~wdata;
        @(negedge clk);
        check_val({tag, ":mem_valid"}, 32'(mem_valid), 32'd1);
        check_val({tag, ":mem_addr"},  mem_addr, {addr[31:2], 2'b00});
        check_val({tag, ":mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
        check_val({tag, ":mem_instr"}, 32'(mem_instr), 32'(instr));
        if (wr) check_val({tag, ":mem_wdata"}, mem_wdata, exp_wdata);
        if (early) begin
            mem_ready = 1'b1; mem_rdata = ~mword;
        end
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = mword;
        @(negedge clk);
        check_val({tag, ":rsp_valid_early"}, 32'(rsp_valid), 32'd0);
        check_val({tag, ":mem_valid_drop"},  32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        check_val({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_val({tag, ":rsp_error"}, 32'(rsp_error), 32'd0);
        check_val({tag, ":rsp_rdata"}, rsp_rdata, exp_rdata);
        check_val({tag, ":req_ready_ret"}, 32'(req_ready), 32'd1);
    endtask

    // Misaligned/reserved request: immediate error response, no memory access.
    task automatic do_bad(input string tag, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr);
        wait_ready(tag);
        req_valid = 1'b1; req_write = wr; req_size = size; req_addr = addr;
        req_wdata = 32'h1234_5678; req_signed = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_val({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_val({tag, ":rsp_error"}, 32'(rsp_error), 32'd1);
        check_val({tag, ":rsp_rdata"}, rsp_rdata, 32'h0);
        check_val({tag, ":mem_valid"}, 32'(mem_valid), 32'd0);
        check_val({tag, ":req_ready_err"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check_val({tag, ":rsp_valid_end"}, 32'(rsp_valid), 32'd0);
        check_val({tag, ":req_ready_ret"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_instr = 1'b0;
        req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset:req_ready", 32'(req_ready), 32'd0);
        check_val("reset:rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("reset:rsp_error", 32'(rsp_error), 32'd0);
        check_val("reset:rsp_rdata", rsp_rdata, 32'h0);
        check_val("reset:mem_valid", 32'(mem_valid), 32'd0);
        check_val("reset:mem_addr",  mem_addr, 32'h0);
        check_val("reset:mem_wstrb", 32'(mem_wstrb), 32'd0);
        check_val("reset:mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_reset:req_ready", 32'(req_ready), 32'd1);

        // Stray mem_ready while idle must not produce a response.
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0000;
        @(negedge clk);
        check_val("idle_ready:rsp_valid0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_val("idle_ready:rsp_valid1", 32'(rsp_valid), 32'd0);
        mem_ready = 1'b0;

        //     tag        wr  in  size  sg  addr          wdata         mem word      strb     exp wdata     exp rdata     early
        do_req("st_word", 1, 0, 2'd2, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_2222, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0);
        do_req("st_byte", 1, 0, 2'd0, 0, 32'h0000_0103, 32'h0000_00A5, 32'h3333_4444, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1);
        do_req("st_half", 1, 0, 2'd1, 0, 32'h0000_0102, 32'h1234_ABCD, 32'h5555_6666, 4'b1100, 32'hABCD_ABCD, 32'h0,        0);
        do_req("ld_hs",   0, 0, 2'd1, 1, 32'h0000_0102, 32'h0,         32'h8001_1234, 4'b0000, 32'h0,         32'hFFFF_8001, 1);
        do_req("ld_hu",   0, 0, 2'd1, 0, 32'h0000_0102, 32'h0,         32'h8001_1234, 4'b0000, 32'h0,         32'h0000_8001, 0);
        do_req("ld_bs",   0, 0, 2'd0, 1, 32'h0000_0101, 32'h0,         32'h0000_F200, 4'b0000, 32'h0,         32'hFFFF_FFF2, 0);
        do_req("ld_bu",   0, 0, 2'd0, 0, 32'h0000_0101, 32'h0,         32'h0000_F200, 4'b0000, 32'h0,         32'h0000_00F2, 0);
        do_req("ld_b3s",  0, 0, 2'd0, 1, 32'h0000_0207, 32'h0,         32'h7F00_0080, 4'b0000, 32'h0,         32'h0000_007F, 0);
        do_req("ld_hlo",  0, 0, 2'd1, 1, 32'h0000_0300, 32'h0,         32'h1234_7FFE, 4'b0000, 32'h0,         32'h0000_7FFE, 0);
        do_req("fetch",   0, 1, 2'd2, 1, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 4'b0000, 32'h0,         32'hCAFE_F00D, 0);

        do_bad("bad_word", 0, 2'd2, 32'h0000_0106);
        do_bad("bad_half", 1, 2'd1, 32'h0000_0101);
        do_bad("bad_rsvd", 0, 2'd3, 32'h0000_0100);

        // Reset while BUSY drops the in-flight response.
        wait_ready("rst_busy");
        req_valid = 1'b1; req_write = 1'b0; req_instr = 1'b0; req_size = 2'd1;
        req_signed = 1'b0; req_addr = 32'h0000_0102;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h8001_1234;
        @(negedge clk);
        check_val("rst_busy:rsp_valid0", 32'(rsp_valid), 32'd0);
        check_val("rst_busy:req_ready0", 32'(req_ready), 32'd0);
        check_val("rst_busy:mem_valid",  32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check_val("rst_busy:rsp_valid1", 32'(rsp_valid), 32'd0);
        check_val("rst_busy:req_ready1", 32'(req_ready), 32'd1);
        @(negedge clk);
        check_val("rst_busy:rsp_valid2", 32'(rsp_valid), 32'd0);
        do_req("after_rst", 0, 0, 2'd2, 0, 32'h0000_0400, 32'h0, 32'h0BAD_CAFE, 4'b0000, 32'h0, 32'h0BAD_CAFE, 0);

        // Responder silent: watchdog (when built in) or indefinite wait.
        wait_ready("silent");
        req_valid = 1'b1; req_write = 1'b0; req_instr = 1'b0; req_size = 2'd2;
        req_signed = 1'b0; req_addr = 32'h0000_0200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_val("silent:mem_valid", 32'(mem_valid), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_val("silent:no_rsp_busy", 32'(seen), 32'd0);
`ifdef MEM_INIT_TIMEOUT_EN
        @(negedge clk);
        check_val("tmo:rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("tmo:rsp_error", 32'(rsp_error), 32'd1);
        check_val("tmo:rsp_rdata", rsp_rdata, 32'h0);
        check_val("tmo:req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_val("tmo:late_ready_ignored", 32'(seen), 32'd0);
`else
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_val("wait:no_rsp_long", 32'(seen), 32'd0);
        check_val("wait:req_ready_busy", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check_val("wait:rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("wait:rsp_error", 32'(rsp_error), 32'd0);
        check_val("wait:rsp_rdata", rsp_rdata, 32'h1357_9BDF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
